axi2mem_tcdm_wr_unit: RTL and testbench

AXI2MEM_TCDM_WR_UNIT -- requirements
Module: axi2mem_tcdm_wr_unit

---
 rtl/axi2mem_tcdm_wr_unit.sv | 132 +++++++++++++
 tb/tb_axi2mem_tcdm_wr_unit.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2mem_tcdm_wr_unit.sv
// -----------------------------------------------------------------------------
// axi2mem_tcdm_wr_unit
// Turns one AXI write-burst command into a sequence of 64-bit beats, each beat
// split over two 32-bit TCDM lanes (lane 0 = addr, lane 1 = addr+4). Lanes pull
// data from their own write buffer and finish independently; a beat advances
// once both lanes have completed. After the last beat a B response is held
// until accepted.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   cmd_*                  burst command (start address, len-1 in beats, id)
//   wr_data_pop_*          per-lane write buffer interface (data/strb/valid/pop)
//   tcdm_*                 per-lane TCDM write request interface
//   b_valid_o/b_id_o       burst response, b_ready_i accepts it
//   busy_o                 burst in progress (WRITE or RESP)
// -----------------------------------------------------------------------------
module axi2mem_tcdm_wr_unit (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_req_i,
  output logic             cmd_gnt_o,
  input  logic [31:0]      cmd_add_i,
  input  logic [7:0]       cmd_len_i,
  input  logic [5:0]       cmd_id_i,
  input  logic [1:0][31:0] wr_data_pop_dat_i,
  input  logic [1:0][3:0]  wr_data_pop_strb_i,
  input  logic [1:0]       wr_data_pop_valid_i,
  output logic [1:0]       wr_data_pop_req_o,
  output logic [1:0]       tcdm_req_o,
  output logic [1:0][31:0] tcdm_add_o,
  output logic [1:0]       tcdm_we_o,
  output logic [1:0][3:0]  tcdm_be_o,
  output logic [1:0][31:0] tcdm_data_o,
  input  logic [1:0]       tcdm_gnt_i,
  output logic             b_valid_o,
  output logic [5:0]       b_id_o,
  input  logic             b_ready_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_e;

  state_e      state_q;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q;
  logic [5:0]  id_q;
  logic [7:0]  beat_q, beat_d;
  logic [1:0]  lane_done_q;

  logic        in_write;
  logic [1:0]  lane_pend;
  logic [1:0]  lane_req;
  logic [1:0]  lane_cmpl;
  logic        beat_end;

  // Outputs are qualified with rst_ni so that the cycle in which reset is
  // asserted already shows the idle output pattern and no buffer entry is
  // popped by an aborted burst.
  assign in_write  = rst_ni & (state_q == WRITE);
  assign lane_pend = {2{in_write}} & wr_data_pop_valid_i & ~lane_done_q;

  always_comb begin
    lane_req    = '0;
    lane_cmpl   = '0;
    tcdm_add_o  = '0;
    tcdm_be_o   = '0;
    tcdm_data_o = '0;
    for (int i = 0; i < 2; i++) begin
      lane_req[i] = lane_pend[i] & (|wr_data_pop_strb_i[i]);
      // A zero-strobe beat has nothing to write: pop it and call it done.
      lane_cmpl[i] = (lane_req[i] & tcdm_gnt_i[i]) |
                     (lane_pend[i] & ~(|wr_data_pop_strb_i[i]));
      if (lane_req[i]) begin
        tcdm_add_o[i]  = addr_q + 32'(4 * i);
        tcdm_be_o[i]   = wr_data_pop_strb_i[i];
        tcdm_data_o[i] = wr_data_pop_dat_i[i];
      end
    end
  end

  assign tcdm_req_o        = lane_req;
  assign tcdm_we_o         = lane_req;
  assign wr_data_pop_req_o = lane_cmpl;

  assign beat_end = in_write & (&(lane_done_q | lane_cmpl));
  assign addr_d   = addr_q + 32'd8;
  assign beat_d   = beat_q + 8'd1;

  assign cmd_gnt_o = ~rst_ni | (state_q == IDLE);
  assign b_valid_o = rst_ni & (state_q == RESP);
  assign b_id_o    = b_valid_o ? id_q : '0;
  assign busy_o    = rst_ni & (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      id_q        <= '0;
      beat_q      <= '0;
      lane_done_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_req_i) begin
            addr_q      <= cmd_add_i & ~32'h7;
            len_q       <= cmd_len_i;
            id_q        <= cmd_id_i;
            beat_q      <= '0;
            lane_done_q <= '0;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          if (beat_end) begin
            lane_done_q <= '0;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            if (beat_q == len_q) state_q <= RESP;
          end else begin
            lane_done_q <= lane_done_q | lane_cmpl;
          end
        end
        RESP: begin
          if (b_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi2mem_tcdm_wr_unit.sv
// -----------------------------------------------------------------------------
// Bench for axi2mem_tcdm_wr_unit. The bench owns a two-lane write buffer and a
// burst-level reference model: a lane may only work on beat k once the other
// lane has finished beat k-1, its address is base + 8*k + 4*lane, and the
// burst is over when both lanes have consumed len+1 entries.
// -----------------------------------------------------------------------------
module tb_axi2mem_tcdm_wr_unit;

  localparam int P_IDLE = 0;
  localparam int P_WR   = 1;
  localparam int P_RESP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, cmd_req, cmd_gnt;
  logic [31:0]      cmd_add;
  logic [7:0]       cmd_len;
  logic [5:0]       cmd_id;
  logic [1:0][31:0] p_dat;
  logic [1:0][3:0]  p_strb;
  logic [1:0]       p_vld, p_pop;
  logic [1:0]       t_req, t_we, t_gnt;
  logic [1:0][31:0] t_add, t_data;
  logic [1:0][3:0]  t_be;
  logic             b_valid, b_ready, busy;
  logic [5:0]       b_id;
  logic [1:0]       vld_en;

  axi2mem_tcdm_wr_unit dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_req_i(cmd_req), .cmd_gnt_o(cmd_gnt), .cmd_add_i(cmd_add),
    .cmd_len_i(cmd_len), .cmd_id_i(cmd_id),
    .wr_data_pop_dat_i(p_dat), .wr_data_pop_strb_i(p_strb),
    .wr_data_pop_valid_i(p_vld), .wr_data_pop_req_o(p_pop),
    .tcdm_req_o(t_req), .tcdm_add_o(t_add), .tcdm_we_o(t_we),
    .tcdm_be_o(t_be), .tcdm_data_o(t_data), .tcdm_gnt_i(t_gnt),
    .b_valid_o(b_valid), .b_id_o(b_id), .b_ready_i(b_ready), .busy_o(busy)
  );

  // write buffer
  logic [31:0] bdat  [2][16];
  logic [3:0]  bstrb [2][16];
  int          bcnt  [2];
  int          brd   [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      p_vld[i]  = 1'b0;
      p_dat[i]  = '0;
      p_strb[i] = '0;
      if (brd[i] < bcnt[i]) begin
        p_vld[i]  = vld_en[i];
        p_dat[i]  = bdat[i][brd[i]];
        p_strb[i] = bstrb[i][brd[i]];
      end
    end
  end

  // reference model state
  int          phase = P_IDLE;
  logic [31:0] base = '0;
  int          mlen = 0;
  logic [5:0]  mid = '0;
  bit          mvalid = 1'b0;
  int          ncyc = 0, acc_cyc = 0, b_hs = 0;
  int          pop_cnt [2];
  logic [1:0]  pop_s = '0;

  typedef struct {
    int          cyc;
    int          lane;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;
  wr_t wlog[$];

  typedef struct {
    logic [1:0] vld;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [1:0] gnt;
    logic [1:0] req;
    logic [1:0] pop;
  } vec_t;
  vec_t vt [8];

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  // sample outputs at the falling edge and compare with the model
  task automatic smp();
    logic [1:0]  e_req, e_pop;
    logic        e_gnt, e_bv, e_busy;
    logic [31:0] ea;
    @(negedge clk);
    pop_s = p_pop;
    if (!mvalid) return;
    e_req = '0;
    e_pop = '0;
    if (!rst_n) begin
      e_gnt = 1'b1; e_bv = 1'b0; e_busy = 1'b0;
    end else begin
      e_gnt  = (phase == P_IDLE);
      e_bv   = (phase == P_RESP);
      e_busy = (phase != P_IDLE);
      if (phase == P_WR) begin
        for (int i = 0; i < 2; i++) begin
          if (brd[i] <= brd[1-i] && brd[i] <= mlen && p_vld[i]) begin
            if (p_strb[i] != 4'h0) begin
              e_req[i] = 1'b1;
              e_pop[i] = t_gnt[i];
            end else begin
              e_pop[i] = 1'b1;
            end
          end
        end
      end
    end
    chk("cmd_gnt", 64'(cmd_gnt), 64'(e_gnt));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("b_valid", 64'(b_valid), 64'(e_bv));
    if (e_bv) chk("b_id", 64'(b_id), 64'(mid));
    chk("tcdm_req", 64'(t_req), 64'(e_req));
    chk("tcdm_we", 64'(t_we), 64'(e_req));
    chk("pop_req", 64'(p_pop), 64'(e_pop));
    for (int i = 0; i < 2; i++) begin
      if (e_req[i]) begin
        ea = base + 32'(8 * brd[i]) + 32'(4 * i);
        chk($sformatf("tcdm_add%0d", i), 64'(t_add[i]), 64'(ea));
        chk($sformatf("tcdm_be%0d", i), 64'(t_be[i]), 64'(p_strb[i]));
        chk($sformatf("tcdm_data%0d", i), 64'(t_data[i]), 64'(p_dat[i]));
      end
    end
    if (!rst_n) begin
      chk("rst_add", 64'(t_add), 64'h0);
      chk("rst_data", 64'(t_data), 64'h0);
      chk("rst_be_id", 64'({t_be, b_id}), 64'h0);
    end
    for (int i = 0; i < 2; i++)
      if (t_req[i] && t_gnt[i]) wlog.push_back('{ncyc, i, t_add[i], t_data[i], t_be[i]});
  endtask

  // advance the model past the rising edge using this cycle's inputs
  task automatic adv();
    @(posedge clk);
    #1;
    ncyc++;
    if (!rst_n) begin
      phase  = P_IDLE;
      mvalid = 1'b1;
    end else begin
      case (phase)
        P_IDLE: if (cmd_req) begin
          phase   = P_WR;
          base    = cmd_add & ~32'h7;
          mlen    = int'(cmd_len);
          mid     = cmd_id;
          brd[0]  = 0;
          brd[1]  = 0;
          acc_cyc = ncyc - 1;
        end
        P_WR: begin
          for (int i = 0; i < 2; i++)
            if (pop_s[i]) begin brd[i]++; pop_cnt[i]++; end
          if (brd[0] == mlen + 1 && brd[1] == mlen + 1) phase = P_RESP;
        end
        default: if (b_ready) begin phase = P_IDLE; b_hs++; end
      endcase
    end
  endtask

  task automatic cyc();
    smp();
    adv();
  endtask

  task automatic load(input int len, input bit rnd_strb);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k <= len; k++) begin
        bdat[i][k] = $urandom;
        if (!rnd_strb)              bstrb[i][k] = 4'hF;
        else if ($urandom % 4 == 0) bstrb[i][k] = 4'h0;
        else                        bstrb[i][k] = 4'($urandom_range(1, 15));
      end
      bcnt[i] = len + 1;
    end
  endtask

  task automatic issue(input logic [31:0] add, input int len, input logic [5:0] id);
    cmd_add = add;
    cmd_len = 8'(len);
    cmd_id  = id;
    cmd_req = 1'b1;
    cyc();
    cmd_req = 1'b0;
  endtask

  task automatic drain();
    cmd_req = 1'b0;
    vld_en  = 2'b11;
    t_gnt   = 2'b11;
    b_ready = 1'b1;
    for (int k = 0; k < 200 && phase != P_IDLE; k++) cyc();
    chk("drain_timeout", 64'(phase), 64'(P_IDLE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, p0, p1, h0, bv;
    int c [2];
    logic [31:0] wa [4];

    vt[0] = '{2'b11, 4'hF, 4'hF, 2'b11, 2'b11, 2'b11};
    vt[1] = '{2'b11, 4'hF, 4'hF, 2'b00, 2'b11, 2'b00};
    vt[2] = '{2'b01, 4'hF, 4'hF, 2'b11, 2'b01, 2'b01};
    vt[3] = '{2'b10, 4'h3, 4'hC, 2'b10, 2'b10, 2'b10};
    vt[4] = '{2'b11, 4'h0, 4'h5, 2'b00, 2'b10, 2'b01};
    vt[5] = '{2'b11, 4'h0, 4'h0, 2'b00, 2'b00, 2'b11};
    vt[6] = '{2'b00, 4'hF, 4'hF, 2'b11, 2'b00, 2'b00};
    vt[7] = '{2'b11, 4'h8, 4'h1, 2'b01, 2'b11, 2'b01};

    rst_n = 1'b0; cmd_req = 1'b0; cmd_add = '0; cmd_len = '0; cmd_id = '0;
    vld_en = '0; t_gnt = '0; b_ready = 1'b0;
    pop_cnt[0] = 0; pop_cnt[1] = 0;
    cyc(); cyc();
    smp();
    chk("rst_cmd_gnt", 64'(cmd_gnt), 64'h1);
    chk("rst_ctl", 64'({t_req, t_we, p_pop, b_valid, busy}), 64'h0);
    adv();
    rst_n = 1'b1;
    cyc();

    // single-cycle lane decisions in the first cycle of a beat
    foreach (vt[k]) begin
      load(0, 1'b0);
      bstrb[0][0] = vt[k].s0;
      bstrb[1][0] = vt[k].s1;
      vld_en = '0; t_gnt = '0; b_ready = 1'b0;
      issue(32'(k * 256), 0, 6'(k));
      vld_en = vt[k].vld;
      t_gnt  = vt[k].gnt;
      smp();
      chk($sformatf("vec%0d_req", k), 64'(t_req), 64'(vt[k].req));
      chk($sformatf("vec%0d_pop", k), 64'(p_pop), 64'(vt[k].pop));
      adv();
      drain();
    end

    // single beat, grants tied high
    vld_en = 2'b11; t_gnt = 2'b11; b_ready = 1'b0;
    load(0, 1'b0);
    n0 = wlog.size();
    issue(32'h1000, 0, 6'd5);
    cyc();
    chk("r24_nwr", 64'(wlog.size() - n0), 64'd2);
    if (wlog.size() >= n0 + 2) begin
      chk("r24_a0", 64'(wlog[n0].addr), 64'h1000);
      chk("r24_a1", 64'(wlog[n0+1].addr), 64'h1004);
      chk("r24_lat", 64'(wlog[n0].cyc - acc_cyc), 64'd1);
    end
    smp();
    chk("r24_bvalid", 64'(b_valid), 64'h1);
    chk("r24_bid", 64'(b_id), 64'd5);
    b_ready = 1'b1;
    adv();
    chk("r24_gnt_next", 64'(cmd_gnt), 64'h1);
    b_ready = 1'b0;

    // lane 1 grant withheld two cycles every beat
    load(3, 1'b0);
    vld_en = 2'b11;
    n0 = wlog.size(); p0 = pop_cnt[0]; p1 = pop_cnt[1];
    issue(32'h2003, 3, 6'd9);
    for (int b = 0; b < 4; b++) begin
      t_gnt = 2'b01; cyc(); cyc();
      t_gnt = 2'b11; cyc();
    end
    chk("r25_resp", 64'(phase), 64'(P_RESP));
    chk("r25_pops0", 64'(pop_cnt[0] - p0), 64'd4);
    chk("r25_pops1", 64'(pop_cnt[1] - p1), 64'd4);
    chk("r25_nwr", 64'(wlog.size() - n0), 64'd8);
    c[0] = 0; c[1] = 0;
    for (int j = n0; j < wlog.size(); j++) begin
      chk($sformatf("r25_addr_l%0d", wlog[j].lane), 64'(wlog[j].addr),
          64'(32'h2000 + 32'(8 * c[wlog[j].lane]) + 32'(4 * wlog[j].lane)));
      c[wlog[j].lane]++;
    end
    drain();

    // zero strobe on lane 1, first of two beats
    load(1, 1'b0);
    bstrb[1][0] = 4'h0;
    n0 = wlog.size(); p1 = pop_cnt[1]; h0 = b_hs;
    issue(32'h3000, 1, 6'd3);
    drain();
    c[0] = 0; c[1] = 0;
    for (int j = n0; j < wlog.size(); j++) begin
      c[wlog[j].lane]++;
      if (wlog[j].lane == 1) chk("r26_l1_addr", 64'(wlog[j].addr), 64'h300C);
    end
    chk("r26_l0_writes", 64'(c[0]), 64'd2);
    chk("r26_l1_writes", 64'(c[1]), 64'd1);
    chk("r26_l1_pops", 64'(pop_cnt[1] - p1), 64'd2);
    chk("r26_done", 64'(b_hs - h0), 64'd1);

    // address wrap
    load(1, 1'b0);
    n0 = wlog.size();
    wa[0] = 32'hFFFFFFF8; wa[1] = 32'hFFFFFFFC; wa[2] = 32'h0; wa[3] = 32'h4;
    issue(32'hFFFFFFF8, 1, 6'd7);
    drain();
    chk("r27_nwr", 64'(wlog.size() - n0), 64'd4);
    if (wlog.size() >= n0 + 4)
      for (int j = 0; j < 4; j++) chk($sformatf("r27_addr%0d", j), 64'(wlog[n0+j].addr), 64'(wa[j]));

    // response backpressure with a command waiting
    load(0, 1'b0);
    b_ready = 1'b0;
    issue(32'h4000, 0, 6'd42);
    cyc();
    for (int k = 0; k < 5; k++) begin
      cmd_req = 1'b1; cmd_add = 32'h9000; cmd_len = 8'd2; cmd_id = 6'd1;
      smp();
      chk("r28_bvalid", 64'(b_valid), 64'h1);
      chk("r28_bid", 64'(b_id), 64'd42);
      chk("r28_gnt_low", 64'(cmd_gnt), 64'h0);
      adv();
    end
    cmd_req = 1'b0;
    b_ready = 1'b1;
    cyc();
    chk("r28_gnt_after", 64'(cmd_gnt), 64'h1);

    // reset in the second beat of a four-beat burst
    load(3, 1'b0);
    b_ready = 1'b0;
    issue(32'h5000, 3, 6'd11);
    cyc();
    rst_n = 1'b0;
    smp();
    chk("r28_rst_gnt", 64'(cmd_gnt), 64'h1);
    chk("r28_rst_ctl", 64'({t_req, p_pop, b_valid, busy}), 64'h0);
    adv();
    rst_n = 1'b1;
    b_ready = 1'b1;
    bv = 0;
    for (int k = 0; k < 4; k++) begin
      smp();
      if (b_valid) bv++;
      adv();
    end
    chk("r28_no_resp", 64'(bv), 64'h0);

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      vld_en  = 2'($urandom);
      t_gnt   = 2'($urandom);
      b_ready = ($urandom % 3) != 0;
      if (phase == P_IDLE) begin
        if ($urandom % 2 == 1) begin
          int l;
          l = $urandom_range(0, 7);
          load(l, 1'b1);
          cmd_add = $urandom;
          cmd_len = 8'(l);
          cmd_id  = 6'($urandom);
          cmd_req = 1'b1;
        end else begin
          cmd_req = 1'b0;
        end
      end else begin
        cmd_req = ($urandom % 4) == 0;
        cmd_add = $urandom;
        cmd_len = 8'($urandom);
        cmd_id  = 6'($urandom);
      end
      cyc();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
